// File: rtl/button_conditioner.sv
// Conditions the raw active-low move/select buttons into debounced levels and
// single-cycle press pulses, with optional auto-repeat on move and select-wins arbitration.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic move_n,
    input  logic select_n,
    output logic move_pulse,
    output logic select_pulse,
    output logic move_level,
    output logic select_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] RC_DELAY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RC_PERIOD = RW'(REPEAT_PERIOD - 1);

    localparam int MOVE = 0;
    localparam int SEL  = 1;

    logic [1:0] btn_n;
    logic [1:0] level_cur;
    logic [1:0] level_nxt;
    logic [1:0] rise;

    assign btn_n = {select_n, move_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_q, sync1_d;
            logic          sync2_q, sync2_d;
            logic          raw;
            logic          level_q, level_d;
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = btn_n[gi];
                sync2_d = sync1_q;
            end

            assign raw = ~sync2_q;

            // Any sample that agrees with the current level restarts the count.
            always_comb begin
                level_d = level_q;
                cnt_d   = '0;
                if (raw != level_q) begin
                    if (cnt_q == CNT_MAX) begin
                        level_d = raw;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign level_cur[gi] = level_q;
            assign level_nxt[gi] = level_d;
            assign rise[gi]      = level_d & ~level_q;
        end
    endgenerate

    logic          rep_active_q, rep_active_d;
    logic [RW-1:0] rc_q, rc_d;
    logic          rep_fire;

    // rc counts down to the next repeat; it only runs while move stays pressed.
    always_comb begin
        rep_active_d = rep_active_q;
        rc_d         = rc_q;
        rep_fire     = 1'b0;
        if (REPEAT_EN != 0) begin
            if (!level_nxt[MOVE]) begin
                rep_active_d = 1'b0;
                rc_d         = '0;
            end else if (rise[MOVE]) begin
                rep_active_d = 1'b1;
                rc_d         = RC_DELAY;
            end else if (rep_active_q) begin
                if (rc_q == '0) begin
                    rep_fire = 1'b1;
                    rc_d     = RC_PERIOD;
                end else begin
                    rc_d = rc_q - 1'b1;
                end
            end
        end else begin
            rep_active_d = 1'b0;
            rc_d         = '0;
        end
    end

    logic move_evt;
    logic pending_q, pending_d;
    logic move_pulse_q, move_pulse_d;
    logic select_pulse_q, select_pulse_d;

    // Select wins a collision; the deferred move (or a repeat landing on it) goes out next cycle.
    always_comb begin
        move_evt       = rise[MOVE] | rep_fire;
        select_pulse_d = rise[SEL];
        if (rise[SEL]) begin
            move_pulse_d = 1'b0;
            pending_d    = move_evt | pending_q;
        end else begin
            move_pulse_d = move_evt | pending_q;
            pending_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_active_q   <= 1'b0;
            rc_q           <= '0;
            pending_q      <= 1'b0;
            move_pulse_q   <= 1'b0;
            select_pulse_q <= 1'b0;
        end else begin
            rep_active_q   <= rep_active_d;
            rc_q           <= rc_d;
            pending_q      <= pending_d;
            move_pulse_q   <= move_pulse_d;
            select_pulse_q <= select_pulse_d;
        end
    end

    assign move_pulse   = move_pulse_q;
    assign select_pulse = select_pulse_q;
    assign move_level   = level_cur[MOVE];
    assign select_level = level_cur[SEL];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one instance with auto-repeat, one without, sharing stimulus.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic move_n;
    logic select_n;
    logic mp_r, sp_r, ml_r, sl_r;
    logic mp_a, sp_a, ml_a, sl_a;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int exp_mp_r[$];
    int exp_sp_r[$];
    int exp_mp_a[$];
    int exp_sp_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner #(
        .DEBOUNCE_CYCLES(16), .REPEAT_EN(1), .REPEAT_DELAY(64), .REPEAT_PERIOD(32)
    ) dut_r (
        .clk(clk), .rst(rst), .move_n(move_n), .select_n(select_n),
        .move_pulse(mp_r), .select_pulse(sp_r), .move_level(ml_r), .select_level(sl_r)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(16), .REPEAT_EN(0), .REPEAT_DELAY(64), .REPEAT_PERIOD(32)
    ) dut_a (
        .clk(clk), .rst(rst), .move_n(move_n), .select_n(select_n),
        .move_pulse(mp_a), .select_pulse(sp_a), .move_level(ml_a), .select_level(sl_a)
    );

    // Scoreboard: every observed pulse pops the oldest expected cycle for that output.
    always @(negedge clk) begin
        int e;
        if (mp_r) begin
            checks++;
            if (exp_mp_r.size() == 0) begin
                errors++;
                $display("FAIL move_pulse_r: pulse at cycle %0d, required none", cyc);
            end else begin
                e = exp_mp_r.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL move_pulse_r: pulse at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
        if (sp_r) begin
            checks++;
            if (exp_sp_r.size() == 0) begin
                errors++;
                $display("FAIL select_pulse_r: pulse at cycle %0d, required none", cyc);
            end else begin
                e = exp_sp_r.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL select_pulse_r: pulse at cycle %0d, required cycle %0d", cyc, e);
                end
            end
            checks++;
            if (mp_r !== 1'b0) begin
                errors++;
                $display("FAIL collision_r: move_pulse=%b with select_pulse at cycle %0d, required 0", mp_r, cyc);
            end
        end
        if (mp_a) begin
            checks++;
            if (exp_mp_a.size() == 0) begin
                errors++;
                $display("FAIL move_pulse_a: pulse at cycle %0d, required none", cyc);
            end else begin
                e = exp_mp_a.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL move_pulse_a: pulse at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
        if (sp_a) begin
            checks++;
            if (exp_sp_a.size() == 0) begin
                errors++;
                $display("FAIL select_pulse_a: pulse at cycle %0d, required none", cyc);
            end else begin
                e = exp_sp_a.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL select_pulse_a: pulse at cycle %0d, required cycle %0d", cyc, e);
                end
            end
            checks++;
            if (mp_a !== 1'b0) begin
                errors++;
                $display("FAIL collision_a: move_pulse=%b with select_pulse at cycle %0d, required 0", mp_a, cyc);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({mp_r, sp_r, ml_r, sl_r, mp_a, sp_a, ml_a, sl_a} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {mp_r, sp_r, ml_r, sl_r, mp_a, sp_a, ml_a, sl_a});
        end
        rst = 1'b0;
        $display("test_reset: outputs low during reset at cycle %0d", cyc);
    endtask

    task automatic test_leftover(input string name);
        int left;
        left = exp_mp_r.size() + exp_sp_r.size() + exp_mp_a.size() + exp_sp_a.size();
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL %s_missing_pulses: %0d expected pulses never seen, required 0", name, left);
        end
    endtask

    task automatic test_clean_press();
        int d;
        @(negedge clk);
        move_n = 1'b0;
        d = cyc;
        exp_mp_r.push_back(d + 18);
        exp_mp_a.push_back(d + 18);
        wait_cyc(d + 17);
        checks++;
        if (ml_a !== 1'b0) begin errors++; $display("FAIL clean_level_early: got %b, required 0", ml_a); end
        wait_cyc(d + 18);
        checks++;
        if (ml_a !== 1'b1) begin errors++; $display("FAIL clean_level_rise: got %b, required 1", ml_a); end
        wait_cyc(d + 40);
        move_n = 1'b1;
        wait_cyc(d + 57);
        checks++;
        if (ml_a !== 1'b1) begin errors++; $display("FAIL clean_level_hold: got %b, required 1", ml_a); end
        wait_cyc(d + 58);
        checks++;
        if (ml_a !== 1'b0) begin errors++; $display("FAIL clean_level_fall: got %b, required 0", ml_a); end
        wait_cyc(d + 80);
        test_leftover("clean");
        $display("test_clean_press: press driven at cycle %0d, pulse expected at %0d", d, d + 18);
    endtask

    task automatic test_bounce();
        int t;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            select_n = (i % 2 != 0);
            repeat (5) @(negedge clk);
        end
        select_n = 1'b0;
        t = cyc;
        exp_sp_r.push_back(t + 18);
        exp_sp_a.push_back(t + 18);
        wait_cyc(t + 17);
        checks++;
        if (sl_r !== 1'b0) begin errors++; $display("FAIL bounce_level_early: got %b, required 0", sl_r); end
        wait_cyc(t + 18);
        checks++;
        if (sl_r !== 1'b1) begin errors++; $display("FAIL bounce_level_rise: got %b, required 1", sl_r); end
        wait_cyc(t + 30);
        select_n = 1'b1;
        wait_cyc(t + 60);
        test_leftover("bounce");
        $display("test_bounce: stable low from cycle %0d, pulse expected at %0d", t, t + 18);
    endtask

    task automatic test_auto_repeat();
        int d;
        @(negedge clk);
        move_n = 1'b0;
        d = cyc;
        exp_mp_r.push_back(d + 18);
        exp_mp_a.push_back(d + 18);
        for (int k = 0; k < 5; k++) exp_mp_r.push_back(d + 18 + 64 + 32 * k);
        wait_cyc(d + 218);
        move_n = 1'b1;
        wait_cyc(d + 236);
        checks++;
        if (ml_r !== 1'b0) begin errors++; $display("FAIL repeat_level_fall: got %b, required 0", ml_r); end
        wait_cyc(d + 290);
        test_leftover("repeat");
        $display("test_auto_repeat: press at cycle %0d, 6 pulses expected on repeat instance", d);
    endtask

    task automatic test_collision();
        int d;
        @(negedge clk);
        move_n   = 1'b0;
        select_n = 1'b0;
        d = cyc;
        exp_sp_r.push_back(d + 18);
        exp_sp_a.push_back(d + 18);
        exp_mp_r.push_back(d + 19);
        exp_mp_a.push_back(d + 19);
        wait_cyc(d + 30);
        move_n   = 1'b1;
        select_n = 1'b1;
        wait_cyc(d + 70);
        test_leftover("collision");
        $display("test_collision: both pressed at cycle %0d, select at %0d, move at %0d", d, d + 18, d + 19);
    endtask

    task automatic test_reset_mid_op();
        int d;
        int r;
        // Reset part-way through the debounce count.
        @(negedge clk);
        move_n = 1'b0;
        d = cyc;
        wait_cyc(d + 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        checks++;
        if ({mp_r, ml_r, mp_a, ml_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_debounce: got %b, required 0000", {mp_r, ml_r, mp_a, ml_a});
        end
        exp_mp_r.push_back(r + 18);
        exp_mp_a.push_back(r + 18);
        wait_cyc(r + 40);
        // Reset while pressed and waiting for a repeat: the held button is a fresh press.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        checks++;
        if ({mp_r, ml_r, mp_a, ml_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_repeat: got %b, required 0000", {mp_r, ml_r, mp_a, ml_a});
        end
        exp_mp_r.push_back(r + 18);
        exp_mp_a.push_back(r + 18);
        wait_cyc(r + 30);
        move_n = 1'b1;
        wait_cyc(r + 70);
        test_leftover("reset_mid_op");
        $display("test_reset_mid_op: last reset released at cycle %0d, pulse expected at %0d", r, r + 18);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        move_n   = 1'b1;
        select_n = 1'b1;
        test_reset();
        repeat (5) @(negedge clk);
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_collision();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
